// File: rtl/maze_pkg.sv
// Shared types and bit positions for the micro-maze autosolver.
package maze_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_PRESS,
    ST_RELEASE,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam int SEG_TOP    = 0;
  localparam int SEG_RIGHT  = 1;
  localparam int SEG_BOTTOM = 3;
  localparam int SEG_LEFT   = 4;
  localparam int SEG_WIN_LO = 6;
  localparam int SEG_WIN_HI = 7;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

endpackage

// File: rtl/maze_dir_select.sv
// Wall-follower direction choice: right turn, straight, left turn, then back.
module maze_dir_select
  import maze_pkg::*;
(
  input  logic [1:0] heading,
  input  logic [3:0] open_dirs,
  output logic [1:0] dir,
  output logic [3:0] btn
);

  logic [1:0] right_dir;
  logic [1:0] left_dir;
  logic [1:0] back_dir;

  assign right_dir = heading + 2'd1;
  assign left_dir  = heading + 2'd3;
  assign back_dir  = heading + 2'd2;

  always_comb begin
    if (open_dirs[right_dir])      dir = right_dir;
    else if (open_dirs[heading])   dir = heading;
    else if (open_dirs[left_dir])  dir = left_dir;
    else                           dir = back_dir;
  end

  always_comb begin
    btn = 4'b0000;
    case (dir)
      DIR_N:   btn[BTN_UP]    = 1'b1;
      DIR_E:   btn[BTN_RIGHT] = 1'b1;
      DIR_S:   btn[BTN_DOWN]  = 1'b1;
      default: btn[BTN_LEFT]  = 1'b1;
    endcase
  end

endmodule

// File: rtl/maze_autosolver.sv
// Autonomous wall-following player for the micro-maze.
// Optional step budget enabled by defining MAZE_SOLVER_TIMEOUT_EN.
module maze_autosolver
  import maze_pkg::*;
#(
  parameter int SETTLE    = 4,
  parameter int STEP_W    = 10,
  parameter int MAX_STEPS = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        seg_in,
  output logic [3:0]        btn_out,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [STEP_W-1:0] steps,
  output logic [1:0]        heading
);

  localparam int CNT_W = $clog2(SETTLE);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [STEP_W-1:0] STEPS_MAX = '1;

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic              win;
  logic              all_closed;
  logic [3:0]        open_dirs;
  logic [1:0]        sel_dir;
  logic [3:0]        sel_btn;
  logic              budget_hit;
  logic              unused_seg_bits;

  logic [3:0]        btn_nx;
  logic              busy_nx;
  logic              done_nx;
  logic [STEP_W-1:0] steps_nx;
  logic [1:0]        heading_nx;

  // Open mask is indexed by direction (N, E, S, W); bits 2 and 5 duplicate walls.
  assign open_dirs = {~seg_in[SEG_LEFT], ~seg_in[SEG_BOTTOM],
                      ~seg_in[SEG_RIGHT], ~seg_in[SEG_TOP]};
  assign all_closed      = (open_dirs == 4'b0000);
  assign win             = seg_in[SEG_WIN_HI] & seg_in[SEG_WIN_LO];
  assign unused_seg_bits = seg_in[2] ^ seg_in[5];

  maze_dir_select u_dir_select (
    .heading   (heading),
    .open_dirs (open_dirs),
    .dir       (sel_dir),
    .btn       (sel_btn)
  );

`ifdef MAZE_SOLVER_TIMEOUT_EN
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  assign budget_hit = (steps >= STEP_LIMIT);

  always_ff @(posedge clk) begin
    if (!rst_n) fail <= 1'b0;
    else        fail <= (state_nx == ST_FAIL);
  end
`else
  localparam int unused_max_steps = MAX_STEPS;

  assign budget_hit = 1'b0;
  assign fail       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      btn_out <= 4'b0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      steps   <= '0;
      heading <= DIR_E;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      btn_out <= btn_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      steps   <= steps_nx;
      heading <= heading_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: if (start) state_nx = ST_SAMPLE;
      ST_SAMPLE: begin
        if (win)              state_nx = ST_DONE;
        else if (budget_hit)  state_nx = ST_FAIL;
        else if (!all_closed) state_nx = ST_PRESS;
      end
      ST_PRESS:   state_nx = ST_RELEASE;
      ST_RELEASE: if (cnt == CNT_LAST) state_nx = ST_SAMPLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every flag is registered.
  always_comb begin
    btn_nx     = 4'b0000;
    busy_nx    = (state_nx == ST_SAMPLE) || (state_nx == ST_PRESS) ||
                 (state_nx == ST_RELEASE);
    done_nx    = (state_nx == ST_DONE);
    steps_nx   = steps;
    heading_nx = heading;
    cnt_nx     = (state == ST_RELEASE) ? cnt + 1'b1 : '0;
    if ((state == ST_IDLE || state == ST_DONE || state == ST_FAIL) && start) begin
      steps_nx   = '0;
      heading_nx = DIR_E;
    end
    if (state == ST_SAMPLE && state_nx == ST_PRESS) begin
      btn_nx     = sel_btn;
      heading_nx = sel_dir;
      steps_nx   = (steps == STEPS_MAX) ? steps : steps + 1'b1;
    end
  end

endmodule

// File: tb/tb_maze_autosolver.sv
// Self-checking bench for maze_autosolver against a wall-follower reference model.
module tb_maze_autosolver;

  localparam int SETTLE    = 4;
  localparam int STEP_W    = 4;
  localparam int MAX_STEPS = 3;
  localparam int STEP_SAT  = (1 << STEP_W) - 1;
`ifdef MAZE_SOLVER_TIMEOUT_EN
  localparam int RW_STEPS = 3;
`else
  localparam int RW_STEPS = 40;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [7:0]        seg;
  logic [3:0]        btn;
  logic              busy;
  logic              done;
  logic              fail;
  logic [STEP_W-1:0] steps;
  logic [1:0]        heading;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  maze_autosolver #(
    .SETTLE    (SETTLE),
    .STEP_W    (STEP_W),
    .MAX_STEPS (MAX_STEPS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .seg_in  (seg),
    .btn_out (btn),
    .busy    (busy),
    .done    (done),
    .fail    (fail),
    .steps   (steps),
    .heading (heading)
  );

  // Reference: walls per heading index N,E,S,W; try right, straight, left, back.
  function automatic int model_dir(input int hd, input logic [7:0] s);
    int offs[4] = '{1, 0, 3, 2};
    logic [3:0] closed;
    closed = {s[4], s[3], s[1], s[0]};
    for (int i = 0; i < 4; i++) begin
      if (!closed[(hd + offs[i]) % 4]) return (hd + offs[i]) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_btn(input int d);
    case (d)
      0:       return 4'b0001;
      1:       return 4'b1000;
      2:       return 4'b0010;
      default: return 4'b0100;
    endcase
  endfunction

  function automatic logic [7:0] rand_seg();
    logic [7:0] s;
    s = 8'($urandom);
    s[7] = 1'b0;
    if (s[0] & s[1] & s[3] & s[4]) begin
      case ($urandom_range(3, 0))
        0:       s[0] = 1'b0;
        1:       s[1] = 1'b0;
        2:       s[3] = 1'b0;
        default: s[4] = 1'b0;
      endcase
    end
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_press(input int lim, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (btn === 4'b0000 && cyc < lim);
  endtask

  task automatic test_reset();
    int cyc;
    do_reset();
    seg = 8'h0F;
    pulse_start();
    wait_press(10, cyc);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({btn, busy, done, fail} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: btn/busy/done/fail=%b required 0000000", {btn, busy, done, fail});
    end
    n_tests++;
    if (steps !== '0 || heading !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_regs: steps=%0d heading=%0d required steps=0 heading=1", steps, heading);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_straight();
    do_reset();
    seg = 8'h39;
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || btn !== 4'b0) begin
      n_fail++;
      $display("FAIL straight_sample: busy=%b btn=%b required busy=1 btn=0000", busy, btn);
    end
    @(negedge clk);
    n_tests++;
    if (btn !== 4'b1000 || steps !== 4'd1 || heading !== 2'd1) begin
      n_fail++;
      $display("FAIL straight_press: btn=%b steps=%0d heading=%0d required 1000/1/1", btn, steps, heading);
    end
    for (int i = 0; i < SETTLE + 1; i++) begin
      @(negedge clk);
      n_tests++;
      if (btn !== 4'b0) begin
        n_fail++;
        $display("FAIL straight_gap%0d: btn=%b required 0000", i, btn);
      end
    end
    @(negedge clk);
    n_tests++;
    if (btn !== 4'b1000 || steps !== 4'd2) begin
      n_fail++;
      $display("FAIL straight_period: btn=%b steps=%0d required 1000/2", btn, steps);
    end
  endtask

  task automatic test_dead_end();
    int cyc;
    do_reset();
    seg = 8'h0F;
    pulse_start();
    wait_press(10, cyc);
    n_tests++;
    if (btn !== 4'b0100 || heading !== 2'd3) begin
      n_fail++;
      $display("FAIL dead_end: btn=%b heading=%0d required 0100/3", btn, heading);
    end
  endtask

  task automatic test_all_closed();
    logic bad;
    logic seen;
    do_reset();
    seg = 8'h3F;
    pulse_start();
    bad = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (btn !== 4'b0 || steps !== '0 || busy !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL closed_hold: btn=%b steps=%0d busy=%b required 0000/0/1 throughout", btn, steps, busy);
    end
    seg = 8'h39;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clk);
      if (btn !== 4'b0) seen = 1'b1;
    end
    n_tests++;
    if (btn !== 4'b1000) begin
      n_fail++;
      $display("FAIL closed_release: btn=%b required 1000 within 2 cycles", btn);
    end
  endtask

  task automatic test_win();
    do_reset();
    seg = 8'h3F;
    pulse_start();
    repeat (3) @(negedge clk);
    seg = 8'hC0;
    @(negedge clk);
    n_tests++;
    if ({done, busy, fail, btn} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL win: done/busy/fail/btn=%b required 1000000", {done, busy, fail, btn});
    end
    pulse_start();
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0 || steps !== '0) begin
      n_fail++;
      $display("FAIL win_restart: busy=%b done=%b steps=%0d required 1/0/0", busy, done, steps);
    end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL win_redone: done=%b busy=%b required 1/0", done, busy);
    end
  endtask

  task automatic test_random_walk();
    int hd;
    int exp_d;
    int cyc;
    int exp_cyc;
    do_reset();
    hd  = 1;
    seg = rand_seg();
    pulse_start();
    for (int k = 0; k < RW_STEPS; k++) begin
      wait_press(2 + SETTLE + 3, cyc);
      exp_d   = model_dir(hd, seg);
      exp_cyc = (k == 0) ? 1 : 2 + SETTLE;
      n_tests++;
      if (btn !== model_btn(exp_d) || cyc != exp_cyc) begin
        n_fail++;
        $display("FAIL walk_press%0d: btn=%b after %0d cycles required %b after %0d (seg=%h)",
                 k, btn, cyc, model_btn(exp_d), exp_cyc, seg);
      end
      n_tests++;
      if (heading !== 2'(exp_d) || steps !== STEP_W'((k + 1 > STEP_SAT) ? STEP_SAT : k + 1)
          || fail !== 1'b0) begin
        n_fail++;
        $display("FAIL walk_state%0d: heading=%0d steps=%0d fail=%b required %0d/%0d/0",
                 k, heading, steps, fail, exp_d, (k + 1 > STEP_SAT) ? STEP_SAT : k + 1);
      end
      hd  = exp_d;
      seg = rand_seg();
    end
  endtask

`ifdef MAZE_SOLVER_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    logic extra;
    do_reset();
    seg = 8'h39;
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      wait_press(12, cyc);
      n_tests++;
      if (btn !== ((p % 2 == 0) ? 4'b1000 : 4'b0100)) begin
        n_fail++;
        $display("FAIL timeout_press%0d: btn=%b required %b", p, btn,
                 (p % 2 == 0) ? 4'b1000 : 4'b0100);
      end
      seg = (p % 2 == 0) ? 8'h0F : 8'h39;
    end
    extra = 1'b0;
    for (int i = 0; i < 12 && fail !== 1'b1; i++) begin
      @(negedge clk);
      if (btn !== 4'b0) extra = 1'b1;
    end
    n_tests++;
    if (fail !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || steps !== 4'd3 || extra) begin
      n_fail++;
      $display("FAIL timeout: fail=%b busy=%b done=%b steps=%0d extra_press=%b required 1/0/0/3/0",
               fail, busy, done, steps, extra);
    end
  endtask
`endif

  task automatic test_reset_during_press();
    int cyc;
    do_reset();
    seg = 8'h39;
    pulse_start();
    wait_press(10, cyc);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (btn !== 4'b0 || busy !== 1'b0 || steps !== '0 || heading !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_press: btn=%b busy=%b steps=%0d heading=%0d required 0000/0/0/1",
               btn, busy, steps, heading);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    seg   = 8'h3F;
    test_reset();
    test_straight();
    test_dead_end();
    test_all_closed();
    test_win();
    test_random_walk();
`ifdef MAZE_SOLVER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_during_press();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required bench completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maze_autosolver.md
# maze_autosolver

Autonomous player for the micro-maze game. It consumes the maze's 8-bit wall/win display word and drives the four direction buttons, walking the maze with a wall-follower rule until the win indication appears. It sits on the opposite side of the maze core's button/display interface: its `btn_out` feeds the maze's direction inputs, and the maze's display output feeds its `seg_in`. Both blocks run on the same clock.

## Interface
Parameters:
- `SETTLE`, default 4: idle cycles after each button release before walls are re-sampled. Minimum 3.
- `STEP_W`, default 10: width of the step counter.
- `MAX_STEPS`, default 1000: step budget before FAIL. Only used when `MAZE_SOLVER_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin or restart solving. Sampled in IDLE, DONE and FAIL; ignored otherwise.
- `seg_in` in 8: maze display word. Bit 0 = top wall, bits 1/2 = right wall, bit 3 = bottom wall, bits 4/5 = left wall, bits 6/7 = win. A wall bit of 1 means closed.
- `btn_out` out 4: button drive. Bit 0 = up, bit 1 = down, bit 2 = left, bit 3 = right.
- `busy` out 1: solver is active (SAMPLE, PRESS or RELEASE).
- `done` out 1: win reached.
- `fail` out 1: step budget exhausted.
- `steps` out `STEP_W`: number of presses issued since the last start. Saturates at the maximum value.
- `heading` out 2: current heading. 0 = N, 1 = E, 2 = S, 3 = W.

## Operation
- **Wall decode.** The block uses bit 0 for N (top), bit 1 for E (right), bit 3 for S (bottom) and bit 4 for W (left). Bits 2 and 5 are ignored. `win = seg_in[7] & seg_in[6]`.
- **States:** IDLE, SAMPLE, PRESS, RELEASE, DONE, FAIL.
- **IDLE:** on `start`, go to SAMPLE, clear `steps` to 0 and set `heading` to E.
- **SAMPLE, evaluated in this order:**
  - If `win`, go to DONE.
  - Otherwise, if all four walls are closed (maze still in reset or walls not yet valid), remain in SAMPLE.
  - Otherwise, pick a direction with right-hand priority relative to `heading`: right turn, then straight, then left turn, then back. Take the first open direction, register it, update `heading`, and go to PRESS.
- **PRESS:** exactly 1 cycle. `btn_out` is one-hot for the chosen direction. `steps` increments, saturating. Next state is RELEASE.
- **RELEASE:**
  - `btn_out` = 0 for exactly `SETTLE` cycles, then go to SAMPLE.
  - The zero cycles guarantee the maze clears its button-held latch and refreshes both wall halves (alternating-parity update) at the new cell.
- **DONE / FAIL:** hold until `start`. `start` returns to SAMPLE with `steps` cleared and `heading` reset to E. If `win` is still high, the block re-enters DONE on the following cycle.
- **Button discipline.** `btn_out` is nonzero only in PRESS, and never has more than one bit set.
- **Start/reset overlap.** A `start` coinciding with `rst_n` low is lost.

## Timing
- All outputs are registered. Reset values:
  - `btn_out` = 0, `busy` = 0, `done` = 0, `fail` = 0, `steps` = 0.
  - `heading` = 1 (E); the state is IDLE.
- **Latency:**
  - `start` to first SAMPLE: 1 cycle.
  - SAMPLE decision to `btn_out` high: 1 cycle.
  - One step occupies 2 + `SETTLE` cycles (6 with defaults).
- **Reset mid-operation** (any state): on the next edge `btn_out` = 0 and all outputs return to their reset values.
- **Status flags:**
  - `done` and `fail` are mutually exclusive.
  - `busy` drops on the cycle `done` or `fail` rises.

## Configuration
- **`MAZE_SOLVER_TIMEOUT_EN` defined:** on entering SAMPLE, if `steps >= MAX_STEPS`, go to FAIL and assert `fail`. The win check still takes priority.
- **`MAZE_SOLVER_TIMEOUT_EN` undefined:**
  - The comparator is not built.
  - FAIL is unreachable.
  - `fail` is tied to 0.
  - `steps` still counts and saturates.

## Structure
- **Package `maze_pkg`:**
  - Direction enum (N, E, S, W).
  - `seg_in` bit-index constants: top, right, bottom, left, win.
  - `btn_out` bit-index constants: up, down, left, right.
  - State enum.
- **Sub-module `maze_dir_select`:**
  - Combinational.
  - Inputs: `heading`, 4-bit open mask.
  - Outputs: chosen direction, one-hot button vector.
  - Implements the right/straight/left/back priority.

## Test plan
- **Reset:** hold `rst_n` = 0 for 2 cycles. Expect `btn_out` = 0, `busy` = 0, `done` = 0, `fail` = 0, `steps` = 0, `heading` = 1.
- **Straight move:** pulse `start` with `seg_in` = 8'h39 (only E open), heading E. Expect `btn_out` = 4'b1000 for exactly 1 cycle, then 0 for 4 cycles; `steps` = 1; `heading` = 1.
- **Dead end:** heading E, `seg_in` = 8'h0F (only W open). Expect `btn_out` = 4'b0100; `heading` = 3.
- **All walls closed:** `seg_in` = 8'h3F. Expect the block to stay in SAMPLE for 20+ cycles with `btn_out` = 0 and `steps` unchanged. Then apply 8'h39 and expect a right-button press 2 cycles later.
- **Win:** `seg_in` = 8'hC0 while in SAMPLE. Expect `done` = 1 and `busy` = 0 on the next edge, with no press.
- **Timeout, and reset during PRESS:**
  - With the macro defined and `MAX_STEPS` = 3, in a two-cell corridor: expect `fail` = 1 after the 3rd press.
  - Assert `rst_n` = 0 during PRESS: expect `btn_out` = 0 on the next edge.
